// File: rtl/bin_to_display.sv
// Binary to display front end: iterative double-dabble BCD conversion followed by
// leading-zero blanking and minus-sign placement for a bank of 7-segment decoders.
module bin_to_display #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 4,
    parameter bit SIGNED = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      value,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     apaga,
    output logic [DIGITS-1:0]     sinal,
    output logic                  ovf
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        FMT
    } state_t;

    state_t             state_q, state_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   mag_q, mag_d;
    logic [BW-1:0]      bcd_q, bcd_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               lost_q, lost_d;
    logic [BW-1:0]      digits_q, digits_d;
    logic [DIGITS-1:0]  apaga_q, apaga_d;
    logic [DIGITS-1:0]  sinal_q, sinal_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;

    logic               value_neg;
    logic [WIDTH-1:0]   value_mag;
    logic [BW-1:0]      adj_bcd;
    int                 top_n;
    logic [DIGITS-1:0]  fmt_apaga;
    logic [DIGITS-1:0]  fmt_sinal;
    logic               sign_ovf;

    // Two's complement magnitude; the most negative value maps to 2^(WIDTH-1) unsigned.
    assign value_neg = SIGNED && value[WIDTH-1];
    assign value_mag = value_neg ? (~value + WIDTH'(1)) : value;

    always_comb begin
        adj_bcd = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj_bcd[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Blanking and sign placement from the number of significant digits.
    always_comb begin
        top_n     = 1;
        fmt_apaga = '0;
        fmt_sinal = '0;
        for (int i = 1; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) begin
                top_n = i + 1;
            end
        end
        for (int i = 0; i < DIGITS; i++) begin
            fmt_apaga[i] = (i >= top_n);
            if (neg_q && (top_n < DIGITS) && (i == top_n)) begin
                fmt_sinal[i] = 1'b1;
                fmt_apaga[i] = 1'b0;
            end
        end
        sign_ovf = neg_q && (top_n == DIGITS);
    end

    always_comb begin
        state_d  = state_q;
        neg_d    = neg_q;
        mag_d    = mag_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        lost_d   = lost_q;
        digits_d = digits_q;
        apaga_d  = apaga_q;
        sinal_d  = sinal_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    neg_d   = value_neg;
                    mag_d   = value_mag;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    lost_d  = 1'b0;
                    state_d = CONV;
                end
            end
            CONV: begin
                bcd_d  = {adj_bcd[BW-2:0], mag_q[WIDTH-1]};
                mag_d  = {mag_q[WIDTH-2:0], 1'b0};
                lost_d = lost_q | adj_bcd[BW-1];
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = FMT;
                end
            end
            FMT: begin
                digits_d = bcd_q;
                apaga_d  = fmt_apaga;
                sinal_d  = fmt_sinal;
                ovf_d    = lost_q | sign_ovf;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            neg_q    <= 1'b0;
            mag_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            lost_q   <= 1'b0;
            digits_q <= '0;
            apaga_q  <= '1;
            sinal_q  <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            neg_q    <= neg_d;
            mag_q    <= mag_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            lost_q   <= lost_d;
            digits_q <= digits_d;
            apaga_q  <= apaga_d;
            sinal_q  <= sinal_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign digits = digits_q;
    assign apaga  = apaga_q;
    assign sinal  = sinal_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_bin_to_display.sv
// Bench for bin_to_display: three configurations (signed 4-digit, signed 3-digit,
// unsigned 4-digit) share stimulus and are compared with a decimal reference model.
module tb_bin_to_display;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  value;

    logic        s4_busy, s4_done, s4_ovf;
    logic [15:0] s4_digits;
    logic [3:0]  s4_apaga, s4_sinal;
    logic        s3_busy, s3_done, s3_ovf;
    logic [11:0] s3_digits;
    logic [2:0]  s3_apaga, s3_sinal;
    logic        u4_busy, u4_done, u4_ovf;
    logic [15:0] u4_digits;
    logic [3:0]  u4_apaga, u4_sinal;

    int checks = 0;
    int errors = 0;

    bin_to_display #(.WIDTH(8), .DIGITS(4), .SIGNED(1'b1)) dut_s4 (
        .clk(clk), .reset(reset), .start(start), .value(value),
        .busy(s4_busy), .done(s4_done), .digits(s4_digits),
        .apaga(s4_apaga), .sinal(s4_sinal), .ovf(s4_ovf)
    );

    bin_to_display #(.WIDTH(8), .DIGITS(3), .SIGNED(1'b1)) dut_s3 (
        .clk(clk), .reset(reset), .start(start), .value(value),
        .busy(s3_busy), .done(s3_done), .digits(s3_digits),
        .apaga(s3_apaga), .sinal(s3_sinal), .ovf(s3_ovf)
    );

    bin_to_display #(.WIDTH(8), .DIGITS(4), .SIGNED(1'b0)) dut_u4 (
        .clk(clk), .reset(reset), .start(start), .value(value),
        .busy(u4_busy), .done(u4_done), .digits(u4_digits),
        .apaga(u4_apaga), .sinal(u4_sinal), .ovf(u4_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Decimal reference: digit extraction by division, blanking from digit count.
    task automatic model(input logic [7:0] v, input int nd, input bit sgn,
                         output logic [15:0] dg, output logic [3:0] ap,
                         output logic [3:0] sg, output logic ov);
        int iv, mag, lim, rem, n, d;
        bit neg;
        iv  = sgn ? int'($signed(v)) : int'(v);
        neg = (iv < 0);
        mag = neg ? -iv : iv;
        lim = 10 ** nd;
        rem = mag % lim;
        dg  = '0;
        n   = 1;
        for (int i = 0; i < nd; i++) begin
            d = (rem / (10 ** i)) % 10;
            dg[4*i +: 4] = d[3:0];
            if (d != 0) n = i + 1;
        end
        ap = '0;
        sg = '0;
        for (int i = 0; i < 4; i++) ap[i] = (i >= n);
        if (neg && n < nd) begin
            sg[n] = 1'b1;
            ap[n] = 1'b0;
        end
        ov = (mag >= lim) || (neg && n == nd);
    endtask

    task automatic check_outputs(input logic [7:0] v);
        logic [15:0] dg;
        logic [3:0]  ap, sg;
        logic        ov;
        model(v, 4, 1'b1, dg, ap, sg, ov);
        check("s4_digits", 32'(s4_digits), 32'(dg));
        check("s4_apaga",  32'(s4_apaga),  32'(ap));
        check("s4_sinal",  32'(s4_sinal),  32'(sg));
        check("s4_ovf",    32'(s4_ovf),    32'(ov));
        model(v, 3, 1'b1, dg, ap, sg, ov);
        check("s3_digits", 32'(s3_digits), 32'(dg[11:0]));
        check("s3_apaga",  32'(s3_apaga),  32'(ap[2:0]));
        check("s3_sinal",  32'(s3_sinal),  32'(sg[2:0]));
        check("s3_ovf",    32'(s3_ovf),    32'(ov));
        model(v, 4, 1'b0, dg, ap, sg, ov);
        check("u4_digits", 32'(u4_digits), 32'(dg));
        check("u4_apaga",  32'(u4_apaga),  32'(ap));
        check("u4_sinal",  32'(u4_sinal),  32'(sg));
        check("u4_ovf",    32'(u4_ovf),    32'(ov));
    endtask

    task automatic check_reset_state();
        check("rst_s4_digits", 32'(s4_digits), 32'h0);
        check("rst_s4_apaga",  32'(s4_apaga),  32'hF);
        check("rst_s4_sinal",  32'(s4_sinal),  32'h0);
        check("rst_s4_busy",   32'(s4_busy),   32'h0);
        check("rst_s4_done",   32'(s4_done),   32'h0);
        check("rst_s4_ovf",    32'(s4_ovf),    32'h0);
        check("rst_s3_apaga",  32'(s3_apaga),  32'h7);
        check("rst_u4_digits", 32'(u4_digits), 32'h0);
    endtask

    // One conversion; optional extra start pulse at cycle 'glitch' must be ignored.
    task automatic convert(input logic [7:0] v, input int glitch);
        int cyc;
        value = v;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
        check("busy_after_start", 32'(s4_busy), 32'h1);
        while (s4_done !== 1'b1 && cyc < 30) begin
            if (cyc == 3) value = 8'($urandom);
            start = (glitch != 0 && cyc == glitch);
            tick();
            cyc++;
        end
        start = 1'b0;
        check("done_seen", 32'(s4_done), 32'h1);
        check("latency", 32'(cyc), 32'd10);
        check("busy_at_done", 32'(s4_busy), 32'h0);
        check("s3_done", 32'(s3_done), 32'h1);
        check("u4_done", 32'(u4_done), 32'h1);
        check_outputs(v);
        tick();
        check("done_pulse_len", 32'(s4_done), 32'h0);
        check("no_queued_start", 32'(s4_busy), 32'h0);
    endtask

    initial begin
        int done_count;
        int last_done;
        logic [7:0] rv;

        reset = 1'b1;
        start = 1'b0;
        value = 8'h00;
        repeat (3) tick();
        check_reset_state();
        reset = 1'b0;
        tick();

        convert(8'd0,   0);
        convert(8'd127, 0);
        convert(8'hFB,  0);
        convert(8'h80,  0);
        convert(8'hFF,  0);

        // Reset asserted at cycle 4 of a conversion.
        value = 8'd55;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check_reset_state();
        reset = 1'b0;
        done_count = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (s4_done === 1'b1) done_count++;
        end
        check("no_done_after_abort", 32'(done_count), 32'd0);

        // Start pulse during busy is ignored and not queued.
        convert(8'd99, 5);
        done_count = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (s4_done === 1'b1) done_count++;
        end
        check("ignored_start_no_done", 32'(done_count), 32'd0);

        // Start held high: back-to-back conversions every 10 cycles.
        value      = 8'd42;
        start      = 1'b1;
        done_count = 0;
        last_done  = 0;
        for (int t = 1; t <= 35; t++) begin
            tick();
            if (s4_done === 1'b1) begin
                done_count++;
                check("held_done_spacing", 32'(t - last_done), 32'd10);
                check("held_digits", 32'(s4_digits), 32'h0042);
                last_done = t;
            end
        end
        check("held_done_count", 32'(done_count), 32'd3);
        start = 1'b0;
        repeat (15) tick();

        for (int k = 0; k < 20; k++) begin
            rv = 8'($urandom_range(0, 255));
            convert(rv, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bin_to_display.md
Name: bin_to_display

Overview:
- Sequential front end for a bank of 7-segment digit decoders.
- Takes a signed or unsigned binary value and converts it to BCD with an iterative double-dabble engine, one bit per clock.
- Produces, per digit position, the 4-bit digit code, a blank flag (`apaga`) and a minus-sign flag (`sinal`), which feed the per-digit decoders directly.
- Performs leading-zero suppression and places the minus sign immediately left of the most significant digit.

Parameters:
- WIDTH, 8: width of the binary input value.
- DIGITS, 4: number of display positions driven; position 0 is the units digit.
- SIGNED, 1: 1 means `value` is two's complement; 0 means unsigned, and `sinal` is never asserted.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a conversion of `value`; sampled only in IDLE.
- value  in  WIDTH  binary value to display; captured on the accepted `start` edge.
- busy  out  1  high from the cycle after `start` is accepted until `done`.
- done  out  1  one-cycle pulse; the display outputs are updated and valid.
- digits  out  4*DIGITS  BCD digit codes; position i is at bits [4i+3:4i].
- apaga  out  DIGITS  per-position blank flag (1 = blank).
- sinal  out  DIGITS  per-position minus-sign flag (1 = show '-').
- ovf  out  1  the magnitude or the sign did not fit in DIGITS positions.

Behaviour:
- Reset (asynchronous, any state): state goes to IDLE and all outputs take these values:
  - `digits` = 0
  - `apaga` = all ones (display dark)
  - `sinal` = 0
  - `busy` = 0
  - `done` = 0
  - `ovf` = 0
- A reset during conversion aborts it with no `done` pulse.
- States: IDLE -> CONV -> FMT -> IDLE.
- IDLE:
  - On `start` = 1, latch `neg` = SIGNED & value[WIDTH-1].
  - Latch `mag` = |value|, held in WIDTH unsigned bits. -2^(WIDTH-1) yields 2^(WIDTH-1) and must not overflow.
  - Clear the BCD shift register (4*DIGITS bits) and the bit counter, then go to CONV.
- CONV: exactly WIDTH cycles. Each cycle does two things:
  - Every BCD nibble >= 5 gets +3.
  - Then {bcd, mag} shifts left by 1.
  - A carry out of the top nibble sets an internal `lost` flag.
  - After the WIDTH-th shift, go to FMT.
- FMT: one cycle. Let n = index of the highest nonzero digit, plus 1 (n = 1 if the value is 0). Register all of the following:
  - `digits` = bcd.
  - `apaga[i]` = 1 for i >= n, else 0. Position 0 is never blanked, so zero shows as "0".
  - If `neg` and n < DIGITS: set `sinal[n]` = 1 and `apaga[n]` = 0. All other `sinal` bits are 0.
  - If `neg` and n == DIGITS: `sinal` = 0 and `ovf` = 1.
  - `ovf` = `lost` | (`neg` & n == DIGITS).
  - Pulse `done`, then go to IDLE.
- Latency: with `start` sampled high in cycle 0, `busy` = 1 in cycles 1..WIDTH+1. `done` = 1 and new outputs appear in cycle WIDTH+2 (cycle 10 for WIDTH = 8), and `busy` = 0 in that cycle.
- Display outputs hold their previous values throughout CONV and FMT; there is no flicker between conversions.
- `start` while `busy` = 1 is ignored and not queued. `start` in the same cycle as `done` is accepted, since the state is IDLE.
- `value` changes after capture have no effect on the running conversion.
- SIGNED = 0: `neg` is forced to 0 and `mag` = value.

Test Plan:
- Reset assert mid-CONV (cycle 4 after start) -> next cycle shows `digits` = 0, `apaga` = 4'b1111, `busy` = 0, and no `done` pulse follows.
- `value` = 8'd0, start -> `done` in cycle 10; `digits` = 16'h0000, `apaga` = 4'b1110, `sinal` = 4'b0000, `ovf` = 0.
- `value` = 8'd127 -> `digits` = 16'h0127, `apaga` = 4'b1000, `sinal` = 0; `value` = 8'hFB (-5) -> `digits` = 16'h0005, `apaga` = 4'b1100, `sinal` = 4'b0010.
- `value` = 8'h80 (-128) -> `digits` = 16'h0128, `apaga` = 4'b0000, `sinal` = 4'b1000, `ovf` = 0. With DIGITS = 3 -> `digits` = 12'h128, `sinal` = 3'b000, `ovf` = 1.
- `start` held high continuously with `value` = 8'd42 -> `done` pulses every 10 cycles. A start pulse in cycle 5 of a conversion of 8'd99 is ignored: exactly one `done`, with `digits` = 16'h0099.
- SIGNED = 0, `value` = 8'hFF -> `digits` = 16'h0255, `apaga` = 4'b1000, `sinal` = 0.
